sysctrl_ng: RTL and testbench
=============================

# sysctrl_ng

Parametrised next-generation system control endpoint between the MCU byte link and the core. It decodes the MCU command stream and provides the following:
- status/ID, LEDs, RGB color and buttons;
- interrupt aggregation;
- a generic config register file keyed by ASCII id;
- N serial ports;
- an external menu ROM reader.

It replaces per-core hard-wired config outputs with a flat, indexable config vector.

## Interface
- CORE_ID, 8'h00: byte returned in the third status byte.
- NUM_PORTS, 1: serial ports, 1..4.
- NUM_BUTTONS, 2: board buttons, 1..8.
- CFG_WORDS, 64: 8-bit config registers for ids 8'h20..8'h20+CFG_WORDS-1, 1..96.
- RESET_TIMEOUT, 80_000_000: clocks until auto-release of main reset.
- MENU_AW, 12: menu ROM address width.

- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- data_in_strobe, data_in_start  in  1  byte valid / first byte of command
- data_in  in  8  MCU byte
- data_out  out  8  reply byte
- int_out_n  out  1  low while any interrupt is pending
- int_in  in  8  external interrupt sources; bit0 is ignored
- int_ack  out  8  one-cycle ack pulse vector
- buttons  in  NUM_BUTTONS  raw buttons (async)
- leds  out  2
- color  out  24
- main_reset  out  2  3=coldboot, 1=reset, 0=run
- cfg  out  8*CFG_WORDS  config vector; word k sits at [8k+7:8k]
- cfg_wr  out  1  one-cycle pulse on any config write
- cfg_idx  out  8  id of the last config write
- port_status  in  32*NUM_PORTS
- port_out_available, port_out_data  in  8*NUM_PORTS
- port_out_strobe  out  NUM_PORTS  one-hot pulse
- port_in_available  in  8*NUM_PORTS
- port_in_strobe  out  NUM_PORTS  one-hot pulse
- port_in_data  out  8
- menu_addr  out  MENU_AW
- menu_data  in  8  synchronous ROM output, 1-cycle latency

## Operation
- Reset values:
  - main_reset=3; timeout counter=RESET_TIMEOUT.
  - leds=0, color=0, data_out=0, cfg=all 0.
  - All strobes and int_ack = 0.
  - coldboot=1, sys_int=1 (so int_out_n=0); buttons_irq_en=1.
  - state=0, menu_addr=0.
- Buttons pass through a 2-flop synchroniser.
- int_out_n = !(sys_int | |int_in[7:1]).
- Command framing:
  - Strobe with start: latch command, state=0, menu_addr=0, data_out=0.
  - Strobe without start: execute the command for the current state, then state++. state saturates at 15.
- Commands, by state:
  - CMD0: returns 8'h5C, 8'h42, CORE_ID; then 0.
  - CMD1: s0 leds<=data_in[1:0].
  - CMD2: bytes are bit-reversed. s0 writes color[15:8], s1 writes [7:0], s2 writes [23:16].
  - CMD3: data_out=buttons, zero-extended; sets buttons_irq_en=1.
  - CMD4:
    - s0 latches id. data_out = current cfg[id] if id is in range, else 0.
    - s1 writes, with 'R' taking priority: id 8'h52 ('R') sets main_reset<=data_in[1:0] and the timeout counter to 0; it does not write cfg.
    - Otherwise, if 8'h20<=id<8'h20+CFG_WORDS, writes cfg word id-8'h20 and pulses cfg_wr with cfg_idx=id.
    - Out-of-range ids are ignored.
  - CMD5: s0 int_ack<=data_in. Every byte returns {int_in[7:1],sys_int}. int_ack[0] clears sys_int on the next cycle.
  - CMD6: data_out={5'b0, !buttons_irq_en, any_port_avail, coldboot}. s0 clears coldboot.
  - CMD7:
    - s0 latches sub and returns NUM_PORTS.
    - s1 latches idx and returns 0 (serial type) if idx<NUM_PORTS, else 8'hFF.
    - s2+ with valid idx:
      - sub0 returns avail_out, avail_in, status[31:24], [23:16], [15:8], [7:0]; then 0.
      - sub1 returns out_data[idx]; port_out_strobe[idx]<=data_in[0].
      - sub2 sets port_in_data<=data_in and pulses port_in_strobe[idx].
    - Invalid idx: returns 0 and raises no strobes.
  - CMD8: data_out<=menu_data; menu_addr++. Wraps at 2^MENU_AW.
  - Any other command: data_out=0, no side effects.
- sys_int is set by any of:
  - a rising edge of "port_out_available[p]!=0" on any port;
  - a synchronised button change while buttons_irq_en=1, which also clears buttons_irq_en.
- Simultaneous set and clear of sys_int: set wins.
- Auto reset release: while the counter is non-zero it decrements; the 1→0 step sets main_reset=0. An MCU 'R' write cancels the countdown.

## Timing
- All outputs are registered.
- data_out is valid one clk after data_in_strobe and holds until the next strobe.
- Strobes and int_ack are exactly one cycle wide; there are no back-to-back strobes without a new data_in_strobe.
- Menu: the first CMD8 read returns ROM[0], which is valid because menu_addr=0 since the start byte and the ROM has 1-cycle latency. The MCU must space strobes ≥2 clk apart.
- reset_n asserted mid-command: everything returns to reset values immediately; the next byte must carry start.

## Test plan
- Power-up: int_out_n=0. CMD0 returns 5C,42,CORE_ID. CMD6 returns 01 then coldboot clears. CMD5 with ack 01 → int_out_n=1 within 2 clk.
- No MCU writes, RESET_TIMEOUT=100: main_reset=3 until clk 100, then 0. A separate run writing CMD4 'R'=1 at clk 10 → main_reset=1 permanently.
- CMD4: id 'S' (8'h53) value 2 → cfg word 51 =8'h02, cfg_wr pulse, cfg_idx=8'h53. Re-read of 'S' returns 02. id 8'h10 → no change.
- NUM_PORTS=2, port1 avail 0→3:
  - sys_int set; CMD6 bit1=1.
  - CMD7 sub1 idx1 with data_in bit0=1 → port_out_strobe=2'b10 for 1 clk.
  - idx 5 → returns FF and no strobe.
- Button toggle: one interrupt only. A second toggle before CMD3 is not reported; after CMD3 re-arm, a new toggle interrupts.
- CMD8 ×4 → menu_addr 0→4, bytes equal ROM[0..3]. At menu_addr=2^MENU_AW-1 the next read wraps to 0.

Source files
------------

// File: rtl/sysctrl_ng_if.sv
// MCU byte link: one strobed command/data byte in, one registered reply byte out.
// No backpressure; the MCU paces strobes at least 2 clk apart.
interface sysctrl_ng_if;
    logic       data_in_strobe;
    logic       data_in_start;
    logic [7:0] data_in;
    logic [7:0] data_out;

    modport master (output data_in_strobe, data_in_start, data_in, input data_out);
    modport slave  (input data_in_strobe, data_in_start, data_in, output data_out);
endinterface

// File: rtl/sysctrl_ng.sv
// System control endpoint: decodes MCU commands into status, config, interrupt, port and menu access.
// Reply and strobes are registered one clk after each data_in_strobe; no backpressure, MCU paces the link.
module sysctrl_ng #(
    parameter logic [7:0] CORE_ID       = 8'h00,
    parameter int         NUM_PORTS     = 1,
    parameter int         NUM_BUTTONS   = 2,
    parameter int         CFG_WORDS     = 64,
    parameter int         RESET_TIMEOUT = 80_000_000,
    parameter int         MENU_AW       = 12
) (
    input  logic                    clk,
    input  logic                    reset_n,
    sysctrl_ng_if.slave             mcu,
    output logic                    int_out_n,
    input  logic [7:0]              int_in,
    output logic [7:0]              int_ack,
    input  logic [NUM_BUTTONS-1:0]  buttons,
    output logic [1:0]              leds,
    output logic [23:0]             color,
    output logic [1:0]              main_reset,
    output logic [8*CFG_WORDS-1:0]  cfg,
    output logic                    cfg_wr,
    output logic [7:0]              cfg_idx,
    input  logic [32*NUM_PORTS-1:0] port_status,
    input  logic [8*NUM_PORTS-1:0]  port_out_available,
    input  logic [8*NUM_PORTS-1:0]  port_out_data,
    output logic [NUM_PORTS-1:0]    port_out_strobe,
    input  logic [8*NUM_PORTS-1:0]  port_in_available,
    output logic [NUM_PORTS-1:0]    port_in_strobe,
    output logic [7:0]              port_in_data,
    output logic [MENU_AW-1:0]      menu_addr,
    input  logic [7:0]              menu_data
);
    logic [7:0]             cmd, id, sub, idx;
    logic [3:0]             state;
    logic [31:0]            tmo;
    logic                   coldboot, sys_int, btn_irq_en;
    logic [NUM_BUTTONS-1:0] btn_m, btn_s, btn_d;
    logic [NUM_PORTS-1:0]   avail_now, avail_prev, idx_hot;
    logic [7:0]             sel_avo, sel_avi, sel_od;
    logic [31:0]            sel_st;
    logic                   idx_ok, btn_irq, sys_set, sys_int_nxt, any_avail;
    logic                   unused_int0;

    assign unused_int0 = int_in[0];

    function automatic logic [7:0] rev8(input logic [7:0] x);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = x[7-i];
        return r;
    endfunction

    function automatic logic cfg_hit(input logic [7:0] x);
        return (x >= 8'h20) && ({24'b0, x} < 32'(32 + CFG_WORDS));
    endfunction

    always_comb begin
        avail_now = '0;
        idx_hot   = '0;
        sel_avo   = '0;
        sel_avi   = '0;
        sel_od    = '0;
        sel_st    = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            avail_now[p] = |port_out_available[8*p +: 8];
            if (idx == 8'(p)) begin
                idx_hot[p] = 1'b1;
                sel_avo    = port_out_available[8*p +: 8];
                sel_avi    = port_in_available[8*p +: 8];
                sel_od     = port_out_data[8*p +: 8];
                sel_st     = port_status[32*p +: 32];
            end
        end
    end

    // A set request on the same cycle as an int_ack[0] clear keeps sys_int high.
    assign idx_ok      = {24'b0, idx} < 32'(NUM_PORTS);
    assign any_avail   = |avail_now;
    assign btn_irq     = (btn_s != btn_d) && btn_irq_en;
    assign sys_set     = btn_irq || (|(avail_now & ~avail_prev));
    assign sys_int_nxt = sys_set ? 1'b1 : (int_ack[0] ? 1'b0 : sys_int);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            main_reset      <= 2'd3;
            tmo             <= 32'(RESET_TIMEOUT);
            leds            <= '0;
            color           <= '0;
            mcu.data_out    <= '0;
            cfg             <= '0;
            cfg_wr          <= 1'b0;
            cfg_idx         <= '0;
            int_ack         <= '0;
            port_out_strobe <= '0;
            port_in_strobe  <= '0;
            port_in_data    <= '0;
            coldboot        <= 1'b1;
            sys_int         <= 1'b1;
            int_out_n       <= 1'b0;
            btn_irq_en      <= 1'b1;
            state           <= '0;
            menu_addr       <= '0;
            cmd             <= '0;
            id              <= '0;
            sub             <= '0;
            idx             <= '0;
            btn_m           <= '0;
            btn_s           <= '0;
            btn_d           <= '0;
            avail_prev      <= '0;
        end else begin
            btn_m           <= buttons;
            btn_s           <= btn_m;
            btn_d           <= btn_s;
            avail_prev      <= avail_now;
            sys_int         <= sys_int_nxt;
            int_out_n       <= !(sys_int_nxt || (|int_in[7:1]));
            cfg_wr          <= 1'b0;
            int_ack         <= '0;
            port_out_strobe <= '0;
            port_in_strobe  <= '0;

            if (tmo != 32'd0) begin
                tmo <= tmo - 32'd1;
                if (tmo == 32'd1) main_reset <= 2'd0;
            end

            if (mcu.data_in_strobe && mcu.data_in_start) begin
                cmd          <= mcu.data_in;
                state        <= '0;
                menu_addr    <= '0;
                mcu.data_out <= '0;
            end else if (mcu.data_in_strobe) begin
                if (state != 4'hF) state <= state + 4'd1;
                mcu.data_out <= '0;
                case (cmd)
                    8'h00: case (state)
                        4'd0:    mcu.data_out <= 8'h5C;
                        4'd1:    mcu.data_out <= 8'h42;
                        4'd2:    mcu.data_out <= CORE_ID;
                        default: ;
                    endcase
                    8'h01: if (state == 4'd0) leds <= mcu.data_in[1:0];
                    8'h02: case (state)
                        4'd0:    color[15:8]  <= rev8(mcu.data_in);
                        4'd1:    color[7:0]   <= rev8(mcu.data_in);
                        4'd2:    color[23:16] <= rev8(mcu.data_in);
                        default: ;
                    endcase
                    8'h03: begin
                        mcu.data_out <= 8'(btn_s);
                        btn_irq_en   <= 1'b1;
                    end
                    8'h04: if (state == 4'd0) begin
                        id <= mcu.data_in;
                        if (cfg_hit(mcu.data_in))
                            mcu.data_out <= cfg[8*(int'(mcu.data_in) - 32) +: 8];
                    end else if (state == 4'd1) begin
                        // 'R' drives the core reset and is never stored as a config word.
                        if (id == 8'h52) begin
                            main_reset <= mcu.data_in[1:0];
                            tmo        <= '0;
                        end else if (cfg_hit(id)) begin
                            cfg[8*(int'(id) - 32) +: 8] <= mcu.data_in;
                            cfg_wr  <= 1'b1;
                            cfg_idx <= id;
                        end
                    end
                    8'h05: begin
                        mcu.data_out <= {int_in[7:1], sys_int};
                        if (state == 4'd0) int_ack <= mcu.data_in;
                    end
                    8'h06: begin
                        mcu.data_out <= {5'b0, !btn_irq_en, any_avail, coldboot};
                        if (state == 4'd0) coldboot <= 1'b0;
                    end
                    8'h07: if (state == 4'd0) begin
                        sub          <= mcu.data_in;
                        mcu.data_out <= 8'(NUM_PORTS);
                    end else if (state == 4'd1) begin
                        idx          <= mcu.data_in;
                        mcu.data_out <= ({24'b0, mcu.data_in} < 32'(NUM_PORTS)) ? 8'h00 : 8'hFF;
                    end else if (idx_ok) begin
                        case (sub)
                            8'd0: case (state)
                                4'd2:    mcu.data_out <= sel_avo;
                                4'd3:    mcu.data_out <= sel_avi;
                                4'd4:    mcu.data_out <= sel_st[31:24];
                                4'd5:    mcu.data_out <= sel_st[23:16];
                                4'd6:    mcu.data_out <= sel_st[15:8];
                                4'd7:    mcu.data_out <= sel_st[7:0];
                                default: ;
                            endcase
                            8'd1: begin
                                mcu.data_out    <= sel_od;
                                port_out_strobe <= idx_hot & {NUM_PORTS{mcu.data_in[0]}};
                            end
                            8'd2: begin
                                port_in_data   <= mcu.data_in;
                                port_in_strobe <= idx_hot;
                            end
                            default: ;
                        endcase
                    end
                    8'h08: begin
                        mcu.data_out <= menu_data;
                        menu_addr    <= menu_addr + 1'b1;
                    end
                    default: ;
                endcase
            end

            if (btn_irq) btn_irq_en <= 1'b0;
        end
    end
endmodule

// File: tb/tb_sysctrl_ng.sv
// Directed bench for sysctrl_ng: byte-vector table for reply data plus hand sequences for
// interrupts, config writes, port strobes, buttons, menu reads and reset release.
module tb_sysctrl_ng;
    localparam int NP  = 2;
    localparam int NB  = 2;
    localparam int CW  = 64;
    localparam int MAW = 3;

    typedef logic [8*CW-1:0] wide_t;
    typedef struct {
        logic       st;
        logic [7:0] din;
        logic [7:0] exp;
    } vec_t;

    logic              clk = 1'b0;
    logic              reset_n = 1'b1;
    logic              int_out_n;
    logic [7:0]        int_in = '0;
    logic [7:0]        int_ack;
    logic [NB-1:0]     buttons = '0;
    logic [1:0]        leds, main_reset;
    logic [23:0]       color;
    wide_t             cfg;
    logic              cfg_wr;
    logic [7:0]        cfg_idx;
    logic [32*NP-1:0]  port_status = {32'hDEADBEEF, 32'h01234567};
    logic [8*NP-1:0]   port_out_available = '0;
    logic [8*NP-1:0]   port_out_data = {8'h99, 8'h88};
    logic [8*NP-1:0]   port_in_available = {8'h11, 8'h22};
    logic [NP-1:0]     port_out_strobe, port_in_strobe;
    logic [7:0]        port_in_data;
    logic [MAW-1:0]    menu_addr;
    logic [7:0]        menu_data = '0;

    sysctrl_ng_if mcu();

    sysctrl_ng #(
        .CORE_ID(8'hA7), .NUM_PORTS(NP), .NUM_BUTTONS(NB), .CFG_WORDS(CW),
        .RESET_TIMEOUT(100), .MENU_AW(MAW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .mcu(mcu),
        .int_out_n(int_out_n), .int_in(int_in), .int_ack(int_ack),
        .buttons(buttons), .leds(leds), .color(color), .main_reset(main_reset),
        .cfg(cfg), .cfg_wr(cfg_wr), .cfg_idx(cfg_idx),
        .port_status(port_status), .port_out_available(port_out_available),
        .port_out_data(port_out_data), .port_out_strobe(port_out_strobe),
        .port_in_available(port_in_available), .port_in_strobe(port_in_strobe),
        .port_in_data(port_in_data), .menu_addr(menu_addr), .menu_data(menu_data)
    );

    always #5 clk = ~clk;

    // Synchronous ROM model: ROM[a] = A0 + a.
    always @(posedge clk) menu_data <= 8'hA0 + {5'b0, menu_addr};

    int          checks = 0;
    int          failures = 0;
    logic [7:0]  s_dout, s_ack, s_ack2;
    logic [NP-1:0] s_pos, s_pos2, s_pis, s_pis2;
    logic        s_cw, s_cw2;
    wide_t       exp_cfg;
    vec_t        tbl[$];

    task automatic chk(input string nm, input wide_t act, input wide_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic xfer(input logic st, input logic [7:0] d);
        @(negedge clk);
        mcu.data_in_strobe = 1'b1;
        mcu.data_in_start  = st;
        mcu.data_in        = d;
        @(negedge clk);
        mcu.data_in_strobe = 1'b0;
        mcu.data_in_start  = 1'b0;
        s_dout = mcu.data_out;
        s_pos  = port_out_strobe;
        s_pis  = port_in_strobe;
        s_ack  = int_ack;
        s_cw   = cfg_wr;
        @(negedge clk);
        s_pos2 = port_out_strobe;
        s_pis2 = port_in_strobe;
        s_ack2 = int_ack;
        s_cw2  = cfg_wr;
    endtask

    task automatic xchk(input string nm, input logic st, input logic [7:0] d, input logic [7:0] exp);
        xfer(st, d);
        chk(nm, wide_t'(s_dout), wide_t'(exp));
    endtask

    task automatic add(input logic st, input logic [7:0] d, input logic [7:0] e);
        vec_t v;
        v.st = st; v.din = d; v.exp = e;
        tbl.push_back(v);
    endtask

    initial begin
        mcu.data_in_strobe = 1'b0;
        mcu.data_in_start  = 1'b0;
        mcu.data_in        = '0;
        exp_cfg            = '0;

        // CMD0 status/ID
        add(1, 8'h00, 8'h00); add(0, 8'hFF, 8'h5C); add(0, 8'hFF, 8'h42);
        add(0, 8'hFF, 8'hA7); add(0, 8'hFF, 8'h00);
        // CMD6 coldboot read then cleared
        add(1, 8'h06, 8'h00); add(0, 8'h00, 8'h01); add(0, 8'h00, 8'h00);
        // CMD1 leds, CMD2 color, unknown CMD9
        add(1, 8'h01, 8'h00); add(0, 8'h02, 8'h00);
        add(1, 8'h02, 8'h00); add(0, 8'h01, 8'h00); add(0, 8'h03, 8'h00); add(0, 8'hF0, 8'h00);
        add(1, 8'h09, 8'h00); add(0, 8'h55, 8'h00);
        // CMD7 sub0 idx1 info, then invalid idx5
        add(1, 8'h07, 8'h00); add(0, 8'h00, 8'h02); add(0, 8'h01, 8'h00);
        add(0, 8'h00, 8'h00); add(0, 8'h00, 8'h11); add(0, 8'h00, 8'hDE);
        add(0, 8'h00, 8'hAD); add(0, 8'h00, 8'hBE); add(0, 8'h00, 8'hEF); add(0, 8'h00, 8'h00);
        add(1, 8'h07, 8'h00); add(0, 8'h00, 8'h02); add(0, 8'h05, 8'hFF); add(0, 8'h00, 8'h00);

        // Reset values
        #2 reset_n = 1'b0;
        idle(3);
        chk("rst_main_reset", wide_t'(main_reset), wide_t'(2'd3));
        chk("rst_int_out_n", wide_t'(int_out_n), wide_t'(1'b0));
        chk("rst_data_out", wide_t'(mcu.data_out), '0);
        chk("rst_cfg", cfg, '0);
        chk("rst_misc", wide_t'({leds, color, int_ack, port_out_strobe, port_in_strobe, cfg_wr, menu_addr}), '0);
        reset_n = 1'b1;

        // Auto release after 100 clocks
        repeat (99) @(posedge clk);
        @(negedge clk);
        chk("tmo_before", wide_t'(main_reset), wide_t'(2'd3));
        @(negedge clk);
        chk("tmo_after", wide_t'(main_reset), wide_t'(2'd0));

        foreach (tbl[i]) xchk($sformatf("vec%0d", i), tbl[i].st, tbl[i].din, tbl[i].exp);
        chk("leds", wide_t'(leds), wide_t'(2'd2));
        chk("color", wide_t'(color), wide_t'(24'h0F80C0));

        // Interrupt ack and int_in aggregation
        xfer(1, 8'h05);
        xchk("cmd5_pending", 0, 8'h01, 8'h01);
        chk("int_ack_pulse", wide_t'(s_ack), wide_t'(8'h01));
        chk("int_ack_width", wide_t'(s_ack2), '0);
        chk("int_cleared", wide_t'(int_out_n), wide_t'(1'b1));
        int_in = 8'h81;
        idle(2);
        chk("int_in_hi", wide_t'(int_out_n), wide_t'(1'b0));
        xfer(1, 8'h05);
        xchk("cmd5_int_in", 0, 8'h00, 8'h80);
        int_in = 8'h01;
        idle(2);
        chk("int_in_bit0", wide_t'(int_out_n), wide_t'(1'b1));
        int_in = 8'h00;

        // Config register file
        xfer(1, 8'h04);
        xchk("cfg_s_read0", 0, 8'h53, 8'h00);
        xfer(0, 8'h02);
        exp_cfg[51*8 +: 8] = 8'h02;
        chk("cfg_s_word", cfg, exp_cfg);
        chk("cfg_wr_pulse", wide_t'({s_cw, s_cw2}), wide_t'(2'b10));
        chk("cfg_idx", wide_t'(cfg_idx), wide_t'(8'h53));
        xfer(1, 8'h04);
        xchk("cfg_s_reread", 0, 8'h53, 8'h02);
        xfer(1, 8'h04);
        xchk("cfg_low_read", 0, 8'h10, 8'h00);
        xfer(0, 8'h77);
        chk("cfg_low_nowr", cfg, exp_cfg);
        chk("cfg_low_nopulse", wide_t'(s_cw), '0);
        xfer(1, 8'h04);
        xfer(0, 8'h5F);
        xfer(0, 8'hAA);
        exp_cfg[63*8 +: 8] = 8'hAA;
        xfer(1, 8'h04);
        xchk("cfg_high_read", 0, 8'h60, 8'h00);
        xfer(0, 8'hBB);
        chk("cfg_top_word", cfg, exp_cfg);
        chk("cfg_idx_last", wide_t'(cfg_idx), wide_t'(8'h5F));

        // Serial ports
        port_out_available = {8'h03, 8'h00};
        idle(2);
        chk("port_irq", wide_t'(int_out_n), wide_t'(1'b0));
        xfer(1, 8'h06);
        xchk("cmd6_avail", 0, 8'h00, 8'h02);
        xfer(1, 8'h07); xfer(0, 8'h01); xfer(0, 8'h01);
        xchk("port1_out_data", 0, 8'h01, 8'h99);
        chk("port_out_strobe", wide_t'(s_pos), wide_t'(2'b10));
        chk("port_out_strobe_w", wide_t'(s_pos2), '0);
        xfer(1, 8'h07); xfer(0, 8'h01);
        xchk("idx5_type", 0, 8'h05, 8'hFF);
        xchk("idx5_data", 0, 8'h01, 8'h00);
        chk("idx5_nostrobe", wide_t'({s_pos, s_pis}), '0);
        xfer(1, 8'h07); xfer(0, 8'h02); xfer(0, 8'h00); xfer(0, 8'h5A);
        chk("port_in_data", wide_t'(port_in_data), wide_t'(8'h5A));
        chk("port_in_strobe", wide_t'({s_pis, s_pis2}), wide_t'(4'b0100));
        xfer(1, 8'h05); xfer(0, 8'h01);
        chk("port_irq_ack", wide_t'(int_out_n), wide_t'(1'b1));

        // Buttons: one interrupt until re-armed by CMD3
        buttons = 2'b01;
        idle(5);
        chk("btn_irq", wide_t'(int_out_n), wide_t'(1'b0));
        xfer(1, 8'h06);
        xchk("btn_disarmed", 0, 8'h00, 8'h06);
        xfer(1, 8'h05); xfer(0, 8'h01);
        buttons = 2'b00;
        idle(5);
        chk("btn_second_quiet", wide_t'(int_out_n), wide_t'(1'b1));
        xfer(1, 8'h03);
        xchk("cmd3_buttons", 0, 8'h00, 8'h00);
        xfer(1, 8'h06);
        xchk("btn_rearmed", 0, 8'h00, 8'h02);
        buttons = 2'b10;
        idle(5);
        chk("btn_irq_again", wide_t'(int_out_n), wide_t'(1'b0));
        xfer(1, 8'h03);
        xchk("cmd3_buttons2", 0, 8'h00, 8'h02);

        // Menu ROM reads with address wrap
        xfer(1, 8'h08);
        for (int i = 0; i < 8; i++) begin
            xchk($sformatf("menu%0d", i), 0, 8'h00, 8'hA0 + 8'(i));
            if (i == 3) chk("menu_addr4", wide_t'(menu_addr), wide_t'(3'd4));
        end
        chk("menu_addr_wrap", wide_t'(menu_addr), '0);
        xchk("menu_wrap_data", 0, 8'h00, 8'hA0);

        // Reset mid-command, then MCU 'R' write cancels auto release
        xfer(1, 8'h04); xfer(0, 8'h52);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_vals", wide_t'({main_reset, leds, color, mcu.data_out, int_out_n, menu_addr}),
            wide_t'({2'd3, 2'd0, 24'd0, 8'd0, 1'b0, 3'd0}));
        chk("mid_rst_cfg", cfg, '0);
        @(negedge clk);
        reset_n = 1'b1;
        idle(10);
        xfer(1, 8'h04);
        xchk("r_id_read", 0, 8'h52, 8'h00);
        xfer(0, 8'h01);
        chk("r_main_reset", wide_t'(main_reset), wide_t'(2'd1));
        chk("r_no_cfg", wide_t'({cfg, s_cw}), '0);
        idle(150);
        chk("r_held", wide_t'(main_reset), wide_t'(2'd1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
